// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   SZ_*       : mem_size encodings (byte/half/word/dword)
//   lsu_state_e: bus-access FSM states
//   lane_bits  : number of byte-offset bits for a given data-bus width
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Only 32- and 64-bit buses are supported.
    function automatic int unsigned lane_bits(input int unsigned data_w);
        return (data_w == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the load/store unit.
//   Store side: st_size/st_off/st_wdata -> replicated st_data, st_be lane enables,
//               st_misaligned (also flags dword on a 32-bit bus).
//   Load side : ld_size/ld_off/ld_signed/ld_rdata -> lane-extracted, zero- or
//               sign-extended ld_data.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]                             st_size,
    input  logic [lsu_pkg::lane_bits(DATA_W)-1:0]  st_off,
    input  logic [DATA_W-1:0]                      st_wdata,
    output logic [DATA_W-1:0]                      st_data,
    output logic [DATA_W/8-1:0]                    st_be,
    output logic                                   st_misaligned,
    input  logic [1:0]                             ld_size,
    input  logic [lsu_pkg::lane_bits(DATA_W)-1:0]  ld_off,
    input  logic                                   ld_signed,
    input  logic [DATA_W-1:0]                      ld_rdata,
    output logic [DATA_W-1:0]                      ld_data
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_mask;
    logic [6:0]        ld_w;
    logic              ld_s;

    always_comb begin
        st_data       = '0;
        st_be         = '0;
        st_misaligned = 1'b0;
        case (st_size)
            SZ_BYTE: begin
                st_data = {NB{st_wdata[7:0]}};
                st_be   = NB'(1) << st_off;
            end
            SZ_HALF: begin
                st_data       = {(NB / 2){st_wdata[15:0]}};
                st_be         = NB'(3) << st_off;
                st_misaligned = st_off[0];
            end
            SZ_WORD: begin
                st_data       = {(NB / 4){st_wdata[31:0]}};
                st_be         = NB'(15) << st_off;
                st_misaligned = |st_off[1:0];
            end
            default: begin
                if (DATA_W == 64) begin
                    st_data       = st_wdata;
                    st_be         = '1;
                    st_misaligned = |st_off;
                end else begin
                    st_misaligned = 1'b1;
                end
            end
        endcase
    end

    // Extension is done with a width mask so a full-width access needs no special
    // case: shifting the mask by DATA_W leaves every bit from the data itself.
    always_comb begin
        ld_shift = ld_rdata >> {ld_off, 3'b000};
        ld_w     = 7'(DATA_W);
        ld_s     = 1'b0;
        case (ld_size)
            SZ_BYTE: begin
                ld_w = 7'd8;
                ld_s = ld_shift[7];
            end
            SZ_HALF: begin
                ld_w = 7'd16;
                ld_s = ld_shift[15];
            end
            SZ_WORD: begin
                ld_w = 7'd32;
                ld_s = ld_shift[31];
            end
            default: ;
        endcase
        ld_mask = ~({DATA_W{1'b1}} << ld_w);
        ld_data = (ld_shift & ld_mask) | ({DATA_W{ld_signed & ld_s}} & ~ld_mask);
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: handshaked bus access with lane steering, load
// extension, misalignment and timeout detection, and a pipeline stall.
//   Pipeline side: cpu_en, mem_valid, mem_ifWriteMem, mem_size, mem_signed,
//                  mem_addr, mem_wdata in; wb_loadData, load_valid, lsu_stall,
//                  misaligned, timeout_err out.
//   Bus side     : Address_out, Data_out, byte_en, CPU_MIO, bus_we out;
//                  MIO_ready, Data_in in.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_en,
    input  logic                mem_valid,
    input  logic                mem_ifWriteMem,
    input  logic [1:0]          mem_size,
    input  logic                mem_signed,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [ADDR_W-1:0]   Address_out,
    output logic [DATA_W-1:0]   Data_out,
    output logic [DATA_W/8-1:0] byte_en,
    output logic                CPU_MIO,
    output logic                bus_we,
    input  logic                MIO_ready,
    input  logic [DATA_W-1:0]   Data_in,
    output logic [DATA_W-1:0]   wb_loadData,
    output logic                load_valid,
    output logic                lsu_stall,
    output logic                misaligned,
    output logic                timeout_err
);

    localparam int unsigned NB   = DATA_W / 8;
    localparam int unsigned LB   = lane_bits(DATA_W);
    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    lsu_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NB-1:0]     be_q, be_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [LB-1:0]     off_q, off_d;
    logic              sgn_q, sgn_d;
    logic [DATA_W-1:0] wb_q, wb_d;
    logic              lv_q, lv_d;
    logic              mis_q, mis_d;
    logic              to_q, to_d;

    logic [DATA_W-1:0] st_data;
    logic [NB-1:0]     st_be;
    logic              st_misaligned;
    logic [DATA_W-1:0] ld_data;

    lsu_lane_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .st_size      (mem_size),
        .st_off       (mem_addr[LB-1:0]),
        .st_wdata     (mem_wdata),
        .st_data      (st_data),
        .st_be        (st_be),
        .st_misaligned(st_misaligned),
        .ld_size      (size_q),
        .ld_off       (off_q),
        .ld_signed    (sgn_q),
        .ld_rdata     (Data_in),
        .ld_data      (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        we_d    = we_q;
        size_d  = size_q;
        off_d   = off_q;
        sgn_d   = sgn_q;
        wb_d    = wb_q;
        lv_d    = lv_q;
        mis_d   = mis_q;
        to_d    = to_q;
        // cpu_en low freezes everything, including pending pulses.
        if (cpu_en) begin
            lv_d  = 1'b0;
            mis_d = 1'b0;
            to_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_valid) begin
                        if (st_misaligned) begin
                            mis_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            addr_d  = {mem_addr[ADDR_W-1:LB], {LB{1'b0}}};
                            data_d  = st_data;
                            be_d    = st_be;
                            we_d    = mem_ifWriteMem;
                            size_d  = mem_size;
                            off_d   = mem_addr[LB-1:0];
                            sgn_d   = mem_signed;
                            cnt_d   = '0;
                            state_d = REQ;
                        end
                    end
                end
                REQ: begin
                    cnt_d = cnt_q + 1'b1;
                    if (MIO_ready) begin
                        if (!we_q) begin
                            wb_d = ld_data;
                            lv_d = 1'b1;
                        end
                        state_d = DONE;
                    end else if (TIMEOUT != 0 && cnt_q == CntW'(TIMEOUT - 1)) begin
                        wb_d    = '0;
                        to_d    = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // One non-stalling cycle lets the instruction leave MEM before
                    // IDLE looks at mem_valid again.
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            off_q   <= '0;
            sgn_q   <= 1'b0;
            wb_q    <= '0;
            lv_q    <= 1'b0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            we_q    <= we_d;
            size_q  <= size_d;
            off_q   <= off_d;
            sgn_q   <= sgn_d;
            wb_q    <= wb_d;
            lv_q    <= lv_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
        end
    end

    assign Address_out = addr_q;
    assign Data_out    = data_q;
    assign byte_en     = be_q;
    assign CPU_MIO     = (state_q == REQ);
    assign bus_we      = we_q & (state_q == REQ);
    assign wb_loadData = wb_q;
    assign load_valid  = lv_q;
    assign misaligned  = mis_q;
    assign timeout_err = to_q;
    assign lsu_stall   = (state_q == REQ) || (state_q == IDLE && mem_valid && !st_misaligned);

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 32-bit DUT, TIMEOUT=4
    logic        a_cpu_en, a_valid, a_we, a_sgn, a_ready;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [31:0] a_addr_out, a_dout, a_wb;
    logic [3:0]  a_be;
    logic        a_mio, a_bwe, a_lv, a_stall, a_mis, a_to;

    // 64-bit DUT, TIMEOUT=16
    logic        b_cpu_en, b_valid, b_we, b_sgn, b_ready;
    logic [1:0]  b_size;
    logic [31:0] b_addr;
    logic [63:0] b_wdata, b_rdata;
    logic [31:0] b_addr_out;
    logic [63:0] b_dout, b_wb;
    logic [7:0]  b_be;
    logic        b_mio, b_bwe, b_lv, b_stall, b_mis, b_to;

    logic [31:0] exp_wb32;

    mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst(rst), .cpu_en(a_cpu_en), .mem_valid(a_valid),
        .mem_ifWriteMem(a_we), .mem_size(a_size), .mem_signed(a_sgn), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .Address_out(a_addr_out), .Data_out(a_dout), .byte_en(a_be),
        .CPU_MIO(a_mio), .bus_we(a_bwe), .MIO_ready(a_ready), .Data_in(a_rdata),
        .wb_loadData(a_wb), .load_valid(a_lv), .lsu_stall(a_stall), .misaligned(a_mis),
        .timeout_err(a_to)
    );

    mem_stage_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) dut64 (
        .clk(clk), .rst(rst), .cpu_en(b_cpu_en), .mem_valid(b_valid),
        .mem_ifWriteMem(b_we), .mem_size(b_size), .mem_signed(b_sgn), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .Address_out(b_addr_out), .Data_out(b_dout), .byte_en(b_be),
        .CPU_MIO(b_mio), .bus_we(b_bwe), .MIO_ready(b_ready), .Data_in(b_rdata),
        .wb_loadData(b_wb), .load_valid(b_lv), .lsu_stall(b_stall), .misaligned(b_mis),
        .timeout_err(b_to)
    );

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic bit m_misaligned(input bit [1:0] size, input longint unsigned addr,
                                        input int nb);
        int bytes;
        bytes = 1 << size;
        return (bytes > nb) || ((addr % bytes) != 0);
    endfunction

    function automatic longint unsigned m_be(input bit [1:0] size, input longint unsigned addr,
                                             input int nb);
        int bytes;
        bytes = 1 << size;
        return ((longint'(1) << bytes) - 1) << (addr % nb);
    endfunction

    function automatic longint unsigned m_store(input bit [1:0] size, input longint unsigned wd,
                                                input int nb);
        longint unsigned r;
        int bytes;
        bytes = 1 << size;
        r = 0;
        for (int i = 0; i < nb; i++) r |= ((wd >> (8 * (i % bytes))) & 255) << (8 * i);
        return r;
    endfunction

    function automatic longint unsigned m_load(input bit [1:0] size, input bit sgn,
                                               input longint unsigned addr,
                                               input longint unsigned rd, input int nb);
        longint unsigned v, mask;
        int bytes;
        bytes = 1 << size;
        v     = rd >> (8 * (addr % nb));
        mask  = (bytes == 8) ? '1 : ((longint'(1) << (8 * bytes)) - 1);
        v     = v & mask;
        if (sgn && bytes < nb && ((v >> (8 * bytes - 1)) & 1) == 1) v |= ~mask;
        if (nb == 4) v &= 64'hFFFF_FFFF;
        return v;
    endfunction

    // ---------------- 32-bit access driver (observes, does not judge) ----------------
    // Plays the pipeline (drops mem_valid after the first non-stalled cycle) and the
    // bus (MIO_ready after `waits` active REQ cycles; optional 5-cycle cpu_en freeze
    // with MIO_ready held high), then watches 3 more cycles.
    task automatic run32(input bit we, input bit [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits, input int freeze_at,
                         output int n_stall, output int n_mio, output int n_lv,
                         output int n_mis, output int n_to, output logic [31:0] o_addr,
                         output logic [31:0] o_dout, output logic [3:0] o_be,
                         output bit o_we, output bit hung);
        int req_idx, frz_left, tail, cyc;
        bit frozen, drop_next, got;
        n_stall = 0; n_mio = 0; n_lv = 0; n_mis = 0; n_to = 0;
        o_addr = '0; o_dout = '0; o_be = '0; o_we = 1'b1; hung = 1'b0;
        req_idx = 0; frz_left = 0; tail = -1; cyc = 0;
        frozen = 1'b0; drop_next = 1'b0; got = 1'b0;
        a_valid = 1'b1; a_we = we; a_size = size; a_sgn = sgn; a_addr = addr;
        a_wdata = wdata; a_rdata = rdata; a_ready = 1'b0; a_cpu_en = 1'b1;
        while (tail != 0) begin
            if (cyc >= 60) begin
                hung = 1'b1;
                break;
            end
            if (drop_next) begin
                a_valid   = 1'b0;
                drop_next = 1'b0;
            end
            if (frz_left > 0) begin
                frz_left--;
                if (frz_left == 0) a_cpu_en = 1'b1;
            end
            a_ready = 1'b0;
            if (a_mio) begin
                if (!a_cpu_en) begin
                    a_ready = 1'b1;
                end else if (req_idx == freeze_at && !frozen) begin
                    a_cpu_en = 1'b0;
                    frz_left = 5;
                    frozen   = 1'b1;
                    a_ready  = 1'b1;
                end else begin
                    a_ready = (req_idx == waits);
                    req_idx++;
                end
            end
            #1;
            if (a_stall) n_stall++;
            if (a_mio) begin
                n_mio++;
                o_we = o_we & a_bwe;
                if (!got) begin
                    got    = 1'b1;
                    o_addr = a_addr_out;
                    o_dout = a_dout;
                    o_be   = a_be;
                end
            end
            if (a_lv) n_lv++;
            if (a_mis) n_mis++;
            if (a_to) n_to++;
            if (tail > 0) tail--;
            else if (tail < 0 && a_valid && !a_stall) begin
                drop_next = 1'b1;
                tail      = 3;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        a_valid = 1'b0; a_ready = 1'b0; a_cpu_en = 1'b1;
    endtask

    // 64-bit access driver: MIO_ready held high throughout (also outside REQ).
    task automatic run64(input bit we, input bit [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, output int n_lv, output int n_mio,
                         output logic [63:0] o_dout, output logic [7:0] o_be,
                         output bit hung);
        int tail, cyc;
        bit drop_next;
        n_lv = 0; n_mio = 0; o_dout = '0; o_be = '0; hung = 1'b0;
        tail = -1; cyc = 0; drop_next = 1'b0;
        b_valid = 1'b1; b_we = we; b_size = size; b_sgn = sgn; b_addr = addr;
        b_wdata = wdata; b_rdata = rdata; b_ready = 1'b1; b_cpu_en = 1'b1;
        while (tail != 0) begin
            if (cyc >= 30) begin
                hung = 1'b1;
                break;
            end
            if (drop_next) b_valid = 1'b0;
            drop_next = 1'b0;
            #1;
            if (b_mio) begin
                if (n_mio == 0) begin
                    o_dout = b_dout;
                    o_be   = b_be;
                end
                n_mio++;
            end
            if (b_lv) n_lv++;
            if (tail > 0) tail--;
            else if (tail < 0 && b_valid && !b_stall) begin
                drop_next = 1'b1;
                tail      = 3;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        b_valid = 1'b0; b_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        a_cpu_en = 1'b1; a_valid = 1'b0; a_we = 1'b0; a_size = 2'b00; a_sgn = 1'b0;
        a_addr = '0; a_wdata = '0; a_rdata = '0; a_ready = 1'b0;
        b_cpu_en = 1'b1; b_valid = 1'b0; b_we = 1'b0; b_size = 2'b00; b_sgn = 1'b0;
        b_addr = '0; b_wdata = '0; b_rdata = '0; b_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_wb32 = '0;
        checks++;
        if ({a_mio, a_bwe, a_lv, a_mis, a_to, a_stall} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctl32 got=%b exp=000000", {a_mio, a_bwe, a_lv, a_mis, a_to, a_stall});
        end
        checks++;
        if ({a_addr_out, a_dout, a_be, a_wb} !== 100'b0) begin
            failures++;
            $display("FAIL reset_data32 got=%h/%h/%h/%h exp=0", a_addr_out, a_dout, a_be, a_wb);
        end
        checks++;
        if ({b_mio, b_bwe, b_lv, b_mis, b_to, b_stall, b_addr_out, b_dout, b_be, b_wb} !== 174'b0) begin
            failures++;
            $display("FAIL reset_64 got mio=%b addr=%h dout=%h be=%h wb=%h exp=0",
                     b_mio, b_addr_out, b_dout, b_be, b_wb);
        end
    endtask

    task automatic test_lb_signed();
        int ns, nm, nl, nmi, nt; logic [31:0] oa, od; logic [3:0] ob; bit ow, h;
        run32(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_FF12, 0, -1,
              ns, nm, nl, nmi, nt, oa, od, ob, ow, h);
        exp_wb32 = 32'hFFFF_FF80;
        checks++;
        if (h || a_wb !== 32'hFFFF_FF80) begin
            failures++;
            $display("FAIL lb_wb got=%h exp=ffffff80 hung=%0d", a_wb, h);
        end
        checks++;
        if (ob !== 4'b1000 || oa !== 32'h100) begin
            failures++;
            $display("FAIL lb_be_addr got=%b/%h exp=1000/00000100", ob, oa);
        end
        checks++;
        if (ns != 2 || nl != 1 || nm != 1) begin
            failures++;
            $display("FAIL lb_timing got stall=%0d lv=%0d mio=%0d exp=2/1/1", ns, nl, nm);
        end
    endtask

    task automatic test_sh_waits();
        int ns, nm, nl, nmi, nt; logic [31:0] oa, od; logic [3:0] ob; bit ow, h;
        run32(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF, 32'h1234_5678, 3, -1,
              ns, nm, nl, nmi, nt, oa, od, ob, ow, h);
        checks++;
        if (h || od !== 32'hBEEF_BEEF || ob !== 4'b1100 || ow !== 1'b1) begin
            failures++;
            $display("FAIL sh_bus got dout=%h be=%b we=%b exp=beefbeef/1100/1", od, ob, ow);
        end
        checks++;
        if (nm != 4 || nl != 0) begin
            failures++;
            $display("FAIL sh_timing got mio=%0d lv=%0d exp=4/0", nm, nl);
        end
        checks++;
        if (a_wb !== exp_wb32) begin
            failures++;
            $display("FAIL sh_wb_held got=%h exp=%h", a_wb, exp_wb32);
        end
    endtask

    task automatic test_misaligned();
        int ns, nm, nl, nmi, nt; logic [31:0] oa, od; logic [3:0] ob; bit ow, h;
        run32(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hDEAD_BEEF, 0, -1,
              ns, nm, nl, nmi, nt, oa, od, ob, ow, h);
        checks++;
        if (h || nmi != 1 || nm != 0 || ns != 0 || nl != 0) begin
            failures++;
            $display("FAIL lw_misaligned got mis=%0d mio=%0d stall=%0d lv=%0d exp=1/0/0/0",
                     nmi, nm, ns, nl);
        end
    endtask

    task automatic test_timeout();
        int ns, nm, nl, nmi, nt; logic [31:0] oa, od; logic [3:0] ob; bit ow, h;
        run32(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h5555_AAAA, 99, -1,
              ns, nm, nl, nmi, nt, oa, od, ob, ow, h);
        exp_wb32 = '0;
        checks++;
        if (h || nt != 1 || nm != 4 || nl != 0) begin
            failures++;
            $display("FAIL timeout got to=%0d mio=%0d lv=%0d exp=1/4/0", nt, nm, nl);
        end
        checks++;
        if (a_wb !== 32'h0) begin
            failures++;
            $display("FAIL timeout_wb got=%h exp=00000000", a_wb);
        end
    endtask

    task automatic test_freeze();
        int ns, nm, nl, nmi, nt; logic [31:0] oa, od; logic [3:0] ob; bit ow, h;
        run32(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h1234_5678, 3, 1,
              ns, nm, nl, nmi, nt, oa, od, ob, ow, h);
        exp_wb32 = 32'h1234_5678;
        checks++;
        if (h || nl != 1 || nt != 0 || nm != 9 || ns != 10) begin
            failures++;
            $display("FAIL freeze got lv=%0d to=%0d mio=%0d stall=%0d exp=1/0/9/10",
                     nl, nt, nm, ns);
        end
        checks++;
        if (a_wb !== 32'h1234_5678) begin
            failures++;
            $display("FAIL freeze_wb got=%h exp=12345678", a_wb);
        end
    endtask

    task automatic test_back_to_back();
        int ns, nm, nl, nmi, nt; logic [31:0] oa, od; logic [3:0] ob; bit ow, h;
        for (int k = 0; k < 3; k++) begin
            run32(1'b0, 2'b01, 1'b1, 32'h500 + 32'(2 * k), 32'h0, 32'h8765_F00D, 0, -1,
                  ns, nm, nl, nmi, nt, oa, od, ob, ow, h);
            exp_wb32 = 32'(m_load(2'b01, 1'b1, 32'h500 + 2 * k, 32'h8765_F00D, 4));
            checks++;
            if (h || nl != 1 || ns != 2 || a_wb !== exp_wb32) begin
                failures++;
                $display("FAIL b2b_%0d got wb=%h lv=%0d stall=%0d exp=%h/1/2",
                         k, a_wb, nl, ns, exp_wb32);
            end
        end
    endtask

    task automatic test_random();
        int ns, nm, nl, nmi, nt; logic [31:0] oa, od; logic [3:0] ob; bit ow, h;
        bit we, sgn; bit [1:0] size; logic [31:0] addr, wd, rd; int w;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3)); addr = $urandom; wd = $urandom; rd = $urandom;
            w = $urandom_range(0, 5);
            run32(we, size, sgn, addr, wd, rd, w, -1, ns, nm, nl, nmi, nt, oa, od, ob, ow, h);
            checks++;
            if (h) begin
                failures++;
                $display("FAIL rnd%0d_hang got=hung exp=complete", i);
            end else if (m_misaligned(size, addr, 4)) begin
                if (nmi != 1 || nm != 0 || ns != 0 || nl != 0 || a_wb !== exp_wb32) begin
                    failures++;
                    $display("FAIL rnd%0d_mis got mis=%0d mio=%0d stall=%0d wb=%h exp=1/0/0/%h",
                             i, nmi, nm, ns, a_wb, exp_wb32);
                end
            end else if (w >= 4) begin
                exp_wb32 = '0;
                if (nt != 1 || nm != 4 || ns != 5 || nl != 0 || a_wb !== 32'h0) begin
                    failures++;
                    $display("FAIL rnd%0d_to got to=%0d mio=%0d stall=%0d wb=%h exp=1/4/5/0",
                             i, nt, nm, ns, a_wb);
                end
            end else begin
                if (!we) exp_wb32 = 32'(m_load(size, sgn, addr, rd, 4));
                if (nm != w + 1 || ns != w + 2 || nt != 0 || nmi != 0 ||
                    nl != (we ? 0 : 1) || a_wb !== exp_wb32) begin
                    failures++;
                    $display("FAIL rnd%0d_ctl got mio=%0d stall=%0d lv=%0d wb=%h exp=%0d/%0d/%0d/%h",
                             i, nm, ns, nl, a_wb, w + 1, w + 2, we ? 0 : 1, exp_wb32);
                end
                checks++;
                if (oa !== (addr & 32'hFFFF_FFFC) || ob !== 4'(m_be(size, addr, 4)) ||
                    od !== 32'(m_store(size, wd, 4)) || ow !== we) begin
                    failures++;
                    $display("FAIL rnd%0d_bus got a=%h be=%b d=%h we=%b exp=%h/%b/%h/%b", i,
                             oa, ob, od, ow, addr & 32'hFFFF_FFFC, 4'(m_be(size, addr, 4)),
                             32'(m_store(size, wd, 4)), we);
                end
            end
        end
    endtask

    task automatic test_wide_and_reset();
        int nl, nm, cyc; logic [63:0] od; logic [7:0] ob; bit h;
        logic [63:0] exp64;
        run64(1'b0, 2'b01, 1'b0, 32'h6, 64'h0, 64'h8001_0000_0000_0000, nl, nm, od, ob, h);
        checks++;
        if (h || nl != 1 || b_wb !== 64'h0000_0000_0000_8001 || ob !== 8'b1100_0000) begin
            failures++;
            $display("FAIL lhu64 got wb=%h be=%b lv=%0d exp=0000000000008001/11000000/1",
                     b_wb, ob, nl);
        end
        run64(1'b1, 2'b10, 1'b0, 32'h4, 64'h0000_0000_CAFE_F00D, 64'h0, nl, nm, od, ob, h);
        checks++;
        if (h || od !== 64'hCAFE_F00D_CAFE_F00D || ob !== 8'hF0 || nl != 0) begin
            failures++;
            $display("FAIL sw64 got d=%h be=%h lv=%0d exp=cafef00dcafef00d/f0/0", od, ob, nl);
        end
        run64(1'b0, 2'b10, 1'b1, 32'h14, 64'h0, 64'h9000_0001_0000_0000, nl, nm, od, ob, h);
        exp64 = m_load(2'b10, 1'b1, 32'h14, 64'h9000_0001_0000_0000, 8);
        checks++;
        if (h || b_wb !== exp64) begin
            failures++;
            $display("FAIL lw64_signed got=%h exp=%h", b_wb, exp64);
        end
        run64(1'b0, 2'b11, 1'b1, 32'h18, 64'h0, 64'h8123_4567_89AB_CDEF, nl, nm, od, ob, h);
        checks++;
        if (h || b_wb !== 64'h8123_4567_89AB_CDEF || ob !== 8'hFF) begin
            failures++;
            $display("FAIL ld64 got wb=%h be=%h exp=8123456789abcdef/ff", b_wb, ob);
        end
        // Reset asserted between clock edges while REQ is outstanding.
        b_valid = 1'b1; b_we = 1'b0; b_size = 2'b10; b_sgn = 1'b0; b_addr = 32'h20;
        b_ready = 1'b0; b_cpu_en = 1'b1;
        cyc = 0;
        while (!b_mio && cyc < 5) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        b_valid = 1'b0;
        checks++;
        if (b_mio !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_req_start got mio=%b exp=1", b_mio);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (b_mio !== 1'b0 || b_wb !== 64'h0) begin
            failures++;
            $display("FAIL rst_mid_req got mio=%b wb=%h exp=0/0", b_mio, b_wb);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_wb32 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (b_mio !== 1'b0 || b_lv !== 1'b0) begin
            failures++;
            $display("FAIL rst_lost_access got mio=%b lv=%b exp=0/0", b_mio, b_lv);
        end
    endtask

    initial begin
        test_reset();
        test_lb_signed();
        test_sh_waits();
        test_misaligned();
        test_timeout();
        test_freeze();
        test_back_to_back();
        test_random();
        test_wide_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
